reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 131 +++++++++++++
 tb/tb_reg_dump_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks first_addr..last_addr, capturing each word and
// presenting it on a valid/ready port, one word per READ+HOLD pair.
module reg_dump_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cur_reg, cur_next;
  logic [4:0]  last_reg, last_next;
  logic [4:0]  addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cur_reg   <= 5'd0;
      last_reg  <= 5'd0;
      addr_reg  <= 5'd0;
      data_reg  <= 32'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            cur_next   = first_addr;
            last_next  = last_addr;
            state_next = READ;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      READ: begin
        if (abort) begin
          // An abandoned dump leaves the outputs exactly as after reset.
          state_next = IDLE;
          valid_next = 1'b0;
          cur_next   = 5'd0;
          addr_next  = 5'd0;
          data_next  = 32'd0;
        end else begin
          data_next  = rd_data;
          addr_next  = cur_reg;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
          cur_next   = 5'd0;
          addr_next  = 5'd0;
          data_next  = 32'd0;
        end else if (dump_ready) begin
          valid_next = 1'b0;
          // Stop on equality rather than incrementing so last_addr=31 never wraps.
          if (cur_reg == last_reg) begin
            state_next = DONE;
          end else begin
            cur_next   = cur_reg + 5'd1;
            state_next = READ;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_addr    = cur_reg;
  assign dump_valid = valid_reg;
  assign dump_addr  = addr_reg;
  assign dump_data  = data_reg;
  assign busy       = (state_reg == READ) || (state_reg == HOLD);
  assign done       = (state_reg == DONE);
  assign err        = err_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a behavioural register file plus a
// word-queue reference model of the dump, with randomized ranges and back-pressure.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_addr = 5'd0;
  logic [4:0]  last_addr = 5'd0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] regfile [32];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rd_data = regfile[rd_addr];

  reg_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Runs one dump of f..l. Model: every word takes one READ cycle, then is held
  // until accepted; done follows the last accept by one cycle.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                         input int hold_first, input int wr_reg, input bit noise,
                         input string name);
    logic [4:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [4:0]  exp_rd;
    int cyc, last_acc, held;
    bit prev_acc, acc, finished, exp_done, exp_valid;
    for (int i = f; i <= l; i++) begin
      exp_a.push_back(i[4:0]);
      exp_d.push_back(regfile[i]);
    end
    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l; dump_ready = 1'b0; abort = 1'b0;
    cyc = 0; last_acc = 0; held = 0; prev_acc = 1'b0; finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      acc = 1'b0;
      exp_done  = (exp_a.size() == 0) && (cyc == last_acc + 1);
      exp_valid = (exp_a.size() != 0) && (cyc != 1) && !prev_acc;
      exp_rd    = (exp_a.size() == 0) ? l : exp_a[0];
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, done, exp_done);
      end
      vectors++;
      if (busy !== !exp_done) begin
        miscompares++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, busy, !exp_done);
      end
      vectors++;
      if (dump_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL %s dump_valid cyc=%0d got=%b want=%b", name, cyc, dump_valid, exp_valid);
      end
      vectors++;
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s err cyc=%0d got=%b want=0", name, cyc, err);
      end
      vectors++;
      if (rd_addr !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rd_addr cyc=%0d got=%0d want=%0d", name, cyc, rd_addr, exp_rd);
      end
      if (dump_valid === 1'b1 && exp_a.size() != 0) begin
        vectors++;
        if (dump_addr !== exp_a[0] || dump_data !== exp_d[0]) begin
          miscompares++;
          $display("FAIL %s word cyc=%0d got=%0d/%h want=%0d/%h", name, cyc,
                   dump_addr, dump_data, exp_a[0], exp_d[0]);
        end
      end
      if (exp_done) begin
        finished = 1'b1;
      end else if (cyc > 600 || (exp_a.size() == 0 && cyc > last_acc + 1)) begin
        vectors++;
        miscompares++;
        $display("FAIL %s timeout cyc=%0d got=no_done want=done", name, cyc);
        finished = 1'b1;
      end
      if (!finished) begin
        if (held < hold_first && dump_valid === 1'b1) begin
          dump_ready = 1'b0;
          held++;
        end else begin
          dump_ready = ($urandom_range(99) < pct);
        end
        if (wr_reg >= 0 && dump_valid === 1'b1 && dump_addr == wr_reg[4:0])
          regfile[wr_reg] = 32'hDEADBEEF;
        if (noise && $urandom_range(3) == 0) begin
          start = 1'b1; first_addr = 5'd31; last_addr = 5'd0;
        end
        acc = (dump_valid === 1'b1) && dump_ready;
        if (acc) begin
          if (exp_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s extra_word cyc=%0d got=%0d want=none", name, cyc, dump_addr);
          end else begin
            $display("%s word addr=%0d data=%h cyc=%0d", name, dump_addr, dump_data, cyc);
            void'(exp_a.pop_front());
            void'(exp_d.pop_front());
            last_acc = cyc;
          end
        end
      end else begin
        dump_ready = 1'b0;
      end
      prev_acc = acc;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rd_addr, dump_valid, dump_addr, dump_data, busy, done, err} !== 46'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=0",
               {rd_addr, dump_valid, dump_addr, dump_data, busy, done, err});
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) regfile[i] = 32'h01010101 * i;
    do_dump(5'd0, 5'd31, 100, 0, -1, 1'b0, "full");
  endtask

  task automatic test_single_word();
    do_dump(5'd5, 5'd5, 100, 0, -1, 1'b0, "single");
  endtask

  task automatic test_bad_range();
    @(negedge clk);
    start = 1'b1; first_addr = 5'd9; last_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_range pulse got=err%b/busy%b/valid%b want=1/0/0", err, busy, dump_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_range after got=err%b/busy%b/valid%b want=0/0/0", err, busy, dump_valid);
      end
    end
    $display("bad_range start rejected");
  endtask

  task automatic test_top_hold();
    do_dump(5'd30, 5'd31, 100, 4, -1, 1'b0, "top_hold");
  endtask

  task automatic test_write_during_hold();
    do_dump(5'd5, 5'd9, 50, 3, 7, 1'b0, "write_hold");
  endtask

  task automatic test_abort_and_reset();
    int k;
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd10; dump_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!(dump_valid === 1'b1 && dump_addr == 5'd2) && k < 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; dump_ready = 1'b0;
    vectors++;
    if ({rd_addr, dump_valid, dump_addr, dump_data, busy, done, err} !== 46'd0) begin
      miscompares++;
      $display("FAIL abort_state got=%h want=0",
               {rd_addr, dump_valid, dump_addr, dump_data, busy, done, err});
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_idle got=done%b/busy%b/valid%b want=0/0/0", done, busy, dump_valid);
      end
    end
    $display("abort returned to idle");

    start = 1'b1; first_addr = 5'd3; last_addr = 5'd20; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, dump_valid, dump_addr, dump_data, busy, done, err} !== 46'd0) begin
      miscompares++;
      $display("FAIL midreset_state got=%h want=0",
               {rd_addr, dump_valid, dump_addr, dump_data, busy, done, err});
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_hold got=done%b/busy%b want=0/0", done, busy);
    end
    reset = 1'b1;
    dump_ready = 1'b0;
    $display("mid-dump reset abandoned dump");
    do_dump(5'd12, 5'd15, 70, 0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [4:0] a, b;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      a = 5'($urandom_range(31));
      b = 5'($urandom_range(31));
      if (a > b) begin
        a = a ^ b; b = a ^ b; a = a ^ b;
      end
      do_dump(a, b, $urandom_range(100, 30), $urandom_range(3), -1, 1'b1, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'd0;
    test_reset();
    test_full_dump();
    test_single_word();
    test_bad_range();
    test_top_hold();
    test_write_during_hold();
    test_abort_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
